// File: rtl/mnist_argmax.sv
// mnist_argmax: top-1/top-2 tracker for the 10-class FC output stream.
// Collects one signed logit per in_valid, publishes argmax, score and
// top1-top2 margin on a ready/valid result register, and keeps image /
// correct-prediction statistics against an optional label.
module mnist_argmax #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_done,
    input  logic [IDX_W-1:0]  label,
    input  logic              label_valid,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_class,
    output logic [DATA_W-1:0] out_score,
    output logic [DATA_W:0]   out_margin,
    output logic              out_correct,
    output logic              frame_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  img_count,
    output logic [CNT_W-1:0]  correct_count
);

    localparam int CW = $clog2(N_CLASSES + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N_CLASSES);
    localparam logic [CW:0]   N_EFF = (CW + 1)'(N_CLASSES);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W - 1){1'b0}}};

    // collector state
    logic [CW-1:0]             cnt;
    logic signed [DATA_W-1:0]  best_val;
    logic signed [DATA_W-1:0]  second_val;
    logic [IDX_W-1:0]          best_idx;
    logic [IDX_W-1:0]          lbl;
    logic                      lbl_seen;

    // merged (this-cycle) view
    logic                      take;
    logic signed [DATA_W-1:0]  x;
    logic signed [DATA_W-1:0]  best_n;
    logic signed [DATA_W-1:0]  second_n;
    logic [IDX_W-1:0]          idx_n;
    logic [DATA_W:0]           margin_n;
    logic [CW:0]               eff_cnt;
    logic [IDX_W-1:0]          lbl_n;
    logic                      seen_n;
    logic                      correct_n;
    logic                      publish;
    logic                      err;

    // Merge the current logit and label so a frame ending on its last
    // logit publishes without an extra cycle; also decide publish/error.
    always_comb begin
        x        = $signed(in_data);
        take     = in_valid && (cnt < N_CNT);
        best_n   = best_val;
        second_n = second_val;
        idx_n    = best_idx;
        if (take) begin
            if (x > best_val) begin
                second_n = best_val;
                best_n   = x;
                idx_n    = IDX_W'(cnt);
            end else if (x > second_val) begin
                second_n = x;
            end
        end
        margin_n  = {best_n[DATA_W-1], best_n} - {second_n[DATA_W-1], second_n};
        eff_cnt   = {1'b0, cnt} + (CW + 1)'(in_valid);
        lbl_n     = label_valid ? label : lbl;
        seen_n    = label_valid | lbl_seen;
        correct_n = seen_n && (lbl_n == idx_n);
        publish   = in_done && (eff_cnt == N_EFF);
        // short frame on in_done, or an 11th logit with no in_done
        err       = (in_done && (eff_cnt != '0) && (eff_cnt != N_EFF)) ||
                    (!in_done && in_valid && (cnt == N_CNT));
    end

    // Collector: accumulate logits and label, restart on publish or error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            best_val   <= MOST_NEG;
            second_val <= MOST_NEG;
            best_idx   <= '0;
            lbl        <= '0;
            lbl_seen   <= 1'b0;
        end else if (publish || err) begin
            cnt        <= '0;
            best_val   <= MOST_NEG;
            second_val <= MOST_NEG;
            best_idx   <= '0;
            lbl_seen   <= 1'b0;
        end else begin
            if (take) begin
                cnt        <= cnt + CW'(1);
                best_val   <= best_n;
                second_val <= second_n;
                best_idx   <= idx_n;
            end
            if (label_valid) begin
                lbl      <= label;
                lbl_seen <= 1'b1;
            end
        end
    end

    // Result register, handshake, error pulse, overrun flag and statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_class     <= '0;
            out_score     <= '0;
            out_margin    <= '0;
            out_correct   <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            img_count     <= '0;
            correct_count <= '0;
        end else begin
            frame_err <= err;
            if (publish) begin
                out_valid   <= 1'b1;
                out_class   <= idx_n;
                out_score   <= best_n;
                out_margin  <= margin_n;
                out_correct <= correct_n;
                img_count   <= img_count + CNT_W'(1);
                if (correct_n)
                    correct_count <= correct_count + CNT_W'(1);
                // an unaccepted result is being replaced
                if (out_valid && !out_ready)
                    overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mnist_argmax.sv
// Randomized + directed bench for mnist_argmax against a frame-level model
// (queue of logits, argmax by loop at frame end).
module tb_mnist_argmax;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_done = 1'b0;
    logic [3:0]  label = '0;
    logic        label_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [3:0]  out_class;
    logic [15:0] out_score;
    logic [16:0] out_margin;
    logic        out_correct;
    logic        frame_err;
    logic        overrun;
    logic [15:0] img_count;
    logic [15:0] correct_count;

    mnist_argmax dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_done(in_done), .label(label), .label_valid(label_valid),
        .out_ready(out_ready), .out_valid(out_valid), .out_class(out_class),
        .out_score(out_score), .out_margin(out_margin), .out_correct(out_correct),
        .frame_err(frame_err), .overrun(overrun), .img_count(img_count),
        .correct_count(correct_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] q[$];
    logic [3:0]  m_lbl;
    bit          m_seen;
    bit          e_valid, e_err, e_ovr, e_cor;
    logic [3:0]  e_cls;
    logic [15:0] e_score, e_img, e_ccnt;
    logic [16:0] e_margin;
    logic [15:0] vals[16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, e_valid);
        chk("out_class", out_class, e_cls);
        chk("out_score", out_score, e_score);
        chk("out_margin", out_margin, e_margin);
        chk("out_correct", out_correct, e_cor);
        chk("frame_err", frame_err, e_err);
        chk("overrun", overrun, e_ovr);
        chk("img_count", img_count, e_img);
        chk("correct_count", correct_count, e_ccnt);
    endtask

    // one clock cycle: drive inputs, advance the model, step, compare
    task automatic cyc(input bit v, input logic [15:0] d, input bit done,
                       input bit lv, input logic [3:0] l, input bit rdy);
        bit pub;
        int eff, bi, bv, sv, xv;
        in_valid = v; in_data = d; in_done = done;
        label_valid = lv; label = l; out_ready = rdy;
        pub = 0; e_err = 0;
        eff = q.size() + int'(v);
        if (lv) begin m_lbl = l; m_seen = 1; end
        if (done && eff == N) begin
            if (v) q.push_back(d);
            pub = 1;
        end else if ((done && eff != 0) || (!done && v && q.size() == N)) begin
            e_err = 1;
        end else if (v && !done) begin
            q.push_back(d);
        end
        if (pub) begin
            bi = 0; bv = -32768;
            foreach (q[i]) begin
                xv = int'($signed(q[i]));
                if (xv > bv) begin bv = xv; bi = i; end
            end
            sv = -32768;
            foreach (q[i]) begin
                xv = int'($signed(q[i]));
                if (i != bi && xv > sv) sv = xv;
            end
            e_cor = m_seen && (int'(m_lbl) == bi);
            if (e_valid && !rdy) e_ovr = 1;
            e_valid  = 1;
            e_cls    = 4'(bi);
            e_score  = 16'(bv);
            e_margin = 17'(bv - sv);
            e_img++;
            if (e_cor) e_ccnt++;
        end else if (e_valid && rdy) begin
            e_valid = 0;
        end
        if (pub || e_err) begin q.delete(); m_seen = 0; end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1;
        in_valid = 0; in_done = 0; label_valid = 0; out_ready = 0;
        q.delete(); m_seen = 0; m_lbl = 0;
        e_valid = 0; e_err = 0; e_ovr = 0; e_cor = 0;
        e_cls = 0; e_score = 0; e_img = 0; e_ccnt = 0; e_margin = 0;
        #2;
        check_all();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    // n logits from vals[]; done on last logit (same) or one cycle later;
    // optional label on first logit; optional idle gaps between logits
    task automatic frame(input int n, input bit same, input int lbl,
                         input bit rdy, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc(0, '0, 0, 0, '0, rdy);
            cyc(1, vals[i], (i == n - 1) && same, (lbl >= 0) && (i == 0), 4'(lbl), rdy);
        end
        if (!same) cyc(0, '0, 1, 0, '0, rdy);
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 16; i++) vals[i] = v;
    endtask

    logic [15:0] saved_img;
    logic [15:0] pick[4];

    initial begin
        do_reset();

        // max and margin
        fill(16'h0000);
        vals[0] = 16'h0100; vals[1] = 16'h0200; vals[2] = 16'h7F00; vals[3] = 16'h8000;
        frame(10, 1, -1, 1, 0);
        chk("tp1_class", out_class, 4'd2);
        chk("tp1_score", out_score, 16'h7F00);
        chk("tp1_margin", out_margin, 17'h07D00);
        chk("tp1_img", img_count, 16'd1);
        cyc(0, '0, 0, 0, '0, 1);

        // all-equal negative logits, done on a later cycle
        fill(16'hFF00);
        frame(10, 0, -1, 1, 0);
        chk("tie_class", out_class, 4'd0);
        chk("tie_score", out_score, 16'hFF00);
        chk("tie_margin", out_margin, 17'h0);
        vals[7] = 16'hFFFF;
        frame(10, 1, -1, 1, 0);
        chk("neg_class", out_class, 4'd7);
        chk("neg_margin", out_margin, 17'h000FF);

        // label match, then no label
        fill(16'h0000);
        vals[3] = 16'h1000;
        frame(10, 1, 3, 1, 0);
        chk("lbl_correct", out_correct, 1'b1);
        chk("lbl_ccnt", correct_count, 16'd1);
        frame(10, 1, -1, 1, 0);
        chk("nolbl_correct", out_correct, 1'b0);
        chk("nolbl_ccnt", correct_count, 16'd1);
        cyc(0, '0, 0, 0, '0, 1);

        // short frame, then overflow frame
        saved_img = img_count;
        frame(9, 1, -1, 1, 0);
        chk("short_err", frame_err, 1'b1);
        chk("short_nov", out_valid, 1'b0);
        cyc(0, '0, 0, 0, '0, 1);
        chk("short_err_pulse", frame_err, 1'b0);
        for (int i = 0; i < 11; i++) cyc(1, vals[i], 0, 0, '0, 1);
        chk("ovf_err", frame_err, 1'b1);
        cyc(0, '0, 1, 0, '0, 1);
        chk("ovf_done_ignored", frame_err, 1'b0);
        chk("err_img", img_count, saved_img);
        vals[5] = 16'h2000;
        frame(10, 1, 5, 1, 0);
        chk("after_err_class", out_class, 4'd5);
        chk("after_err_img", img_count, saved_img + 16'd1);

        // backpressure across two frames
        saved_img = img_count;
        cyc(0, '0, 0, 0, '0, 0);
        fill(16'h0000); vals[1] = 16'h0300;
        frame(10, 1, -1, 0, 0);
        fill(16'h0000); vals[8] = 16'h0400;
        frame(10, 0, -1, 0, 0);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_class", out_class, 4'd8);
        chk("bp_overrun", overrun, 1'b1);
        chk("bp_img", img_count, saved_img + 16'd2);
        cyc(0, '0, 0, 0, '0, 1);
        chk("bp_drop", out_valid, 1'b0);

        // reset mid-frame
        fill(16'h0001);
        for (int i = 0; i < 5; i++) cyc(1, 16'h7000, 0, 0, '0, 1);
        do_reset();
        vals[4] = 16'h0050;
        frame(10, 1, -1, 1, 0);
        chk("rst_class", out_class, 4'd4);
        chk("rst_img", img_count, 16'd1);
        chk("rst_noerr", frame_err, 1'b0);

        // randomized frames
        for (int f = 0; f < 300; f++) begin
            int n, lb;
            pick[0] = 16'($urandom); pick[1] = 16'($urandom);
            pick[2] = 16'h8000;      pick[3] = 16'h7FFF;
            for (int i = 0; i < 16; i++)
                vals[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom) : pick[$urandom_range(0, 3)];
            case ($urandom_range(0, 9))
                0: n = 9;
                1: n = 11;
                default: n = 10;
            endcase
            lb = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 9));
            frame(n, 1'($urandom), lb, ($urandom_range(0, 3) != 0), 1'($urandom));
            if ($urandom_range(0, 1) == 0) cyc(0, '0, 0, 0, '0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mnist_argmax.md
# mnist_argmax

Classification output stage placed directly downstream of the 32->10 fully connected layer. It consumes the ten signed logits streamed one per `in_valid` pulse and tracks the running top-1 and top-2 scores. On frame end it publishes the predicted digit, its score and the top1-top2 margin on a ready/valid port. It also keeps image and correct-prediction counters against an optional label input.

## Interface
- `N_CLASSES`, 10: logits per frame.
- `DATA_W`, 16: logit width, signed two's complement (Q1.15).
- `IDX_W`, 4: class index width.
- `CNT_W`, 16: statistics counter width.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_data` in DATA_W: signed logit.
- `in_valid` in 1: one logit per high cycle. No backpressure; upstream cannot stall.
- `in_done` in 1: frame end. May coincide with the last `in_valid` or arrive on a later cycle.
- `label` in IDX_W: ground-truth digit.
- `label_valid` in 1: latches `label` for the current frame.
- `out_ready` in 1: downstream accepts the result.
- `out_valid` out 1: result held until accepted.
- `out_class` out IDX_W: argmax index.
- `out_score` out DATA_W: top-1 logit.
- `out_margin` out DATA_W+1: top1 - top2, unsigned.
- `out_correct` out 1: label was seen and equals `out_class`.
- `frame_err` out 1: one-cycle pulse on a malformed frame.
- `overrun` out 1: sticky. Set when a new result overwrites an unaccepted one.
- `img_count` out CNT_W: frames published.
- `correct_count` out CNT_W: correct frames published.

## Operation
- Collector state: `cnt` (0..N_CLASSES), `best_val`/`best_idx`, `second_val`, `lbl`, `lbl_seen`.
  - At frame start: `best_val` = `second_val` = most-negative value (0x8000), `best_idx` = 0.
- Per accepted logit x with index i = `cnt`:
  - If x > `best_val` (strictly greater): `second_val` <- `best_val`, then `best_val` <- x, `best_idx` <- i.
  - Else if x > `second_val`: `second_val` <- x.
  - Ties therefore resolve to the lowest index.
  - Comparisons are signed.
- Frame end: on a cycle with `in_done`=1, the effective count is `cnt` + `in_valid`.
  - The same-cycle logit is merged combinationally before publishing.
  - Effective count == N_CLASSES: publish.
  - Otherwise: pulse `frame_err`, discard the frame, publish nothing, leave the counters unchanged.
- A logit arriving with `cnt` == N_CLASSES and no `in_done` is an overflow: pulse `frame_err`, discard, restart collection.
  - That extra logit is dropped, not taken as index 0 of a new frame.
- After publish or error: collector resets to frame-start values, `lbl_seen` <- 0.
- Label: `label_valid` at any point in the frame, up to and including the `in_done` cycle, latches `label` and sets `lbl_seen`. The last one wins.
- Publish writes the result register:
  - `out_class`, `out_score`, `out_margin` = `best_val` - `second_val` (DATA_W+1 bits, always >= 0), `out_correct`.
  - `out_valid` <- 1; `img_count` += 1; `correct_count` += `out_correct`. Both counters wrap modulo 2^CNT_W.
- Output handshake: the transfer happens on the cycle `out_valid` && `out_ready`; `out_valid` drops on the next edge unless a publish occurs on that same edge.
- Publish while `out_valid`=1 and `out_ready`=0: the new result overwrites the old and `overrun` <- 1. `overrun` clears only on `reset`.
- Collection is never stalled by the output side.

## Timing
- Reset values: all outputs 0; collector at frame-start values.
- `reset` asserted mid-frame aborts the frame immediately; no `frame_err` is produced.
- Latency: the result is visible (`out_valid`=1) on the edge after the `in_done` sample edge (1 cycle).
  - Counters update on that same edge.
- `frame_err`: high for exactly the cycle after the offending sample edge.
- Back-to-back frames: `in_valid` may be high on the cycle after `in_done`; that logit is index 0 of the next frame.
- `in_done` with `cnt`=0 and `in_valid`=0: ignored. This is not an error.

## Test plan
- Max and margin: logits 0x0100, 0x0200, 0x7F00, 0x8000, then six of 0x0000; `out_ready`=1.
  - Expect `out_class`=2, `out_score`=0x7F00, `out_margin`=0x7D00, `img_count`=1, one cycle after `in_done`.
- Negative logits and tie: all ten logits = 0xFF00.
  - Expect `out_class`=0, `out_score`=0xFF00, `out_margin`=0. Then logit[7]=0xFFFF, others 0xFF00: expect class 7, margin 0x00FF.
- Label: label 3, frame with max at index 3, `out_correct`=1 -> `correct_count`=1. Next frame: no label, `out_correct`=0, `correct_count` unchanged.
- Frame error: nine logits then `in_done` -> `frame_err` pulse, no `out_valid`. Eleven logits -> `frame_err` pulse. Counters unchanged; the next valid frame publishes correctly.
- Backpressure: `out_ready`=0 across two complete frames.
  - Expect `out_valid` held, the second result shown, `overrun`=1, `img_count`=2. Raising `out_ready` drops `out_valid` after one cycle.
- Reset mid-frame: assert `reset` after 5 logits, then send a full 10-logit frame.
  - Expect a correct result, `img_count`=1, no `frame_err`.
